mil_rx_packet_pusher: RTL and testbench
=======================================

// Module: mil_rx_packet_pusher
// PURPOSE
//  Upstream stage of the RingBuffer on the MIL receive path. Groups words from the
//  MIL decoder into packets and pushes each word into the ring through the push port.
//  Uses the ring's open/commit/rollback control so that only complete, error-free
//  packets become visible to the ring's pop side; broken packets are rolled back.
// PARAMETERS
//  GAP_TIMEOUT  16'd200  idle cycles after the last accepted word that end a packet
//  MAX_WORDS    8'd33    max words per packet (command + 32 data); the next word aborts
// PORTS
//  clk            in   1   system clock
//  nRst           in   1   async reset, active low
//  rx_valid       in   1   1-cycle strobe: decoded MIL word available
//  rx_data        in   16  decoded word, sampled when rx_valid=1
//  rx_is_cmd      in   1   1 = command/status word (sync type), 0 = data word
//  rx_error       in   1   1-cycle strobe: parity/Manchester error on current word
//  push_request   out  1   push request to RingBuffer
//  push_data      out  16  word to push; held stable while push_request=1
//  push_done      in   1   1-cycle ack from RingBuffer: word written
//  rb_open        out  1   1-cycle pulse: start ring transaction
//  rb_commit      out  1   1-cycle pulse: publish transaction
//  rb_rollback    out  1   1-cycle pulse: discard transaction
//  pkt_committed  out  1   1-cycle pulse, same cycle as rb_commit
//  pkt_dropped    out  1   1-cycle pulse, same cycle as rb_rollback or on drop in IDLE
//  word_count     out  8   words accepted into current packet
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, holding register empty, gap counter 0.
//  Reset mid-packet returns to IDLE with no commit/rollback pulse; ring reset clears it.
//  Holding register: 1 word. A word is latched on rx_valid and cleared on push_done.
//   rx_valid while register full -> overrun = error event.
//  States:
//   IDLE     : rx_valid & rx_is_cmd & !rx_error -> latch, rb_open pulse (next cycle), PUSH.
//              rx_valid & (!rx_is_cmd | rx_error) -> pkt_dropped pulse, DISCARD.
//   PUSH     : push_request=1 and push_data=holding reg until push_done.
//              On push_done: word_count+1, drop request next cycle, gap counter 0, WAIT.
//              rb_open is issued exactly one cycle before the first push_request.
//   WAIT     : gap counter increments each cycle.
//              rx_valid & !rx_error & word_count<MAX_WORDS -> latch, PUSH.
//              gap counter reaches GAP_TIMEOUT -> COMMIT.
//   COMMIT   : rb_commit and pkt_committed pulse for 1 cycle; word_count 0; IDLE.
//   ROLLBACK : rb_rollback and pkt_dropped pulse for 1 cycle; word_count 0; DISCARD.
//   DISCARD  : ignore input. Any rx_valid or rx_error resets the gap counter.
//              GAP_TIMEOUT idle cycles -> IDLE.
//  Error events (rx_error, overrun, or rx_valid with word_count==MAX_WORDS):
//   in PUSH or WAIT -> ROLLBACK. In PUSH, the pending push is completed first:
//   the request is held until push_done, then ROLLBACK. push_request is never
//   withdrawn before push_done.
//  rx_error and rx_valid in the same cycle: the word is treated as erroneous and is not pushed.
//  A command word in the middle of a packet is a normal word; packets are delimited only by the gap.
//  word_count saturates at MAX_WORDS. The gap counter is 16-bit and saturates.
//  At most one of rb_open, rb_commit and rb_rollback is high in any cycle.
// TESTING
//  1 cmd 16'h0821 + data 16'hABCD, 16'h1234 spaced 50 clk -> open, 3 pushes in order, commit
//    GAP_TIMEOUT clk after last push_done; pkt_committed=1, ring memUsed=3.
//  2 cmd 16'h0821, data 16'h1111, then rx_error -> exactly 1 rb_rollback, pkt_dropped=1,
//    no commit; memUsed=0; the next valid packet after the gap commits normally.
//  3 first word is data 16'h5555 in IDLE -> no rb_open, pkt_dropped=1, DISCARD until gap.
//  4 34 words back-to-back (MAX_WORDS=33) -> 33 pushes, the 34th triggers rollback, memUsed=0.
//  5 hold push_done low 300 clk, send a 2nd rx_valid -> overrun; the 1st push completes, then rollback.
//  6 assert nRst=0 during PUSH -> all outputs 0 asynchronously; after release IDLE, word_count=0.

Source files
------------

// File: rtl/mil_rx_packet_pusher.sv
// mil_rx_packet_pusher
// Groups decoded MIL words into packets and pushes them into the RingBuffer.
// Each packet is wrapped in a ring transaction: opened on the first command
// word, committed after an idle gap, or rolled back on any error so that only
// complete, clean packets ever become visible on the ring's pop side.

module mil_rx_packet_pusher #(
    parameter logic [15:0] GAP_TIMEOUT = 16'd200,
    parameter logic [7:0]  MAX_WORDS   = 8'd33
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        rx_valid,
    input  logic [15:0] rx_data,
    input  logic        rx_is_cmd,
    input  logic        rx_error,
    output logic        push_request,
    output logic [15:0] push_data,
    input  logic        push_done,
    output logic        rb_open,
    output logic        rb_commit,
    output logic        rb_rollback,
    output logic        pkt_committed,
    output logic        pkt_dropped,
    output logic [7:0]  word_count
);

    typedef enum logic [2:0] {
        IDLE,
        OPEN,
        PUSH,
        WAIT,
        COMMIT,
        ROLLBACK,
        DISCARD
    } state_t;

    state_t      state;
    logic        hold_full;
    logic        pending_err;
    logic [15:0] gap_cnt;
    logic [15:0] gap_next;
    logic        err_event;

    // Saturating next value of the idle-gap counter.
    assign gap_next = (gap_cnt == 16'hFFFF) ? gap_cnt : gap_cnt + 16'd1;

    // A word is bad if flagged by the decoder, arrives while the holding
    // register is still occupied, or would exceed the packet length limit.
    assign err_event = rx_error | (rx_valid & (hold_full | (word_count >= MAX_WORDS)));

    // Packet FSM; the holding register doubles as push_data and all outputs are registered.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state         <= IDLE;
            hold_full     <= 1'b0;
            pending_err   <= 1'b0;
            gap_cnt       <= 16'd0;
            push_request  <= 1'b0;
            push_data     <= 16'd0;
            rb_open       <= 1'b0;
            rb_commit     <= 1'b0;
            rb_rollback   <= 1'b0;
            pkt_committed <= 1'b0;
            pkt_dropped   <= 1'b0;
            word_count    <= 8'd0;
        end else begin
            rb_open       <= 1'b0;
            rb_commit     <= 1'b0;
            rb_rollback   <= 1'b0;
            pkt_committed <= 1'b0;
            pkt_dropped   <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_is_cmd && !rx_error) begin
                            push_data   <= rx_data;
                            hold_full   <= 1'b1;
                            pending_err <= 1'b0;
                            rb_open     <= 1'b1;
                            state       <= OPEN;
                        end else begin
                            pkt_dropped <= 1'b1;
                            gap_cnt     <= 16'd0;
                            state       <= DISCARD;
                        end
                    end
                end

                OPEN: begin
                    if (err_event) begin
                        pending_err <= 1'b1;
                    end
                    push_request <= 1'b1;
                    state        <= PUSH;
                end

                PUSH: begin
                    if (push_done) begin
                        push_request <= 1'b0;
                        hold_full    <= 1'b0;
                        gap_cnt      <= 16'd0;
                        if (word_count < MAX_WORDS) begin
                            word_count <= word_count + 8'd1;
                        end
                        if (pending_err || err_event) begin
                            pending_err <= 1'b0;
                            rb_rollback <= 1'b1;
                            pkt_dropped <= 1'b1;
                            state       <= ROLLBACK;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (err_event) begin
                        pending_err <= 1'b1;
                    end
                end

                WAIT: begin
                    if (err_event) begin
                        rb_rollback <= 1'b1;
                        pkt_dropped <= 1'b1;
                        state       <= ROLLBACK;
                    end else if (rx_valid) begin
                        push_data    <= rx_data;
                        hold_full    <= 1'b1;
                        push_request <= 1'b1;
                        state        <= PUSH;
                    end else begin
                        gap_cnt <= gap_next;
                        if (gap_next >= GAP_TIMEOUT) begin
                            rb_commit     <= 1'b1;
                            pkt_committed <= 1'b1;
                            state         <= COMMIT;
                        end
                    end
                end

                COMMIT: begin
                    word_count <= 8'd0;
                    gap_cnt    <= 16'd0;
                    state      <= IDLE;
                end

                ROLLBACK: begin
                    word_count <= 8'd0;
                    gap_cnt    <= 16'd0;
                    state      <= DISCARD;
                end

                DISCARD: begin
                    if (rx_valid || rx_error) begin
                        gap_cnt <= 16'd0;
                    end else if (gap_next >= GAP_TIMEOUT) begin
                        gap_cnt <= 16'd0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_next;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mil_rx_packet_pusher.sv
// tb_mil_rx_packet_pusher
// Directed bench: a small ring model counts opens, pushes, commits and
// rollbacks, and each scenario task compares observed behaviour against
// hand-computed expectations.

module tb_mil_rx_packet_pusher;

    localparam logic [15:0] GAP  = 16'd200;
    localparam logic [7:0]  MAXW = 8'd33;

    logic        clk       = 1'b0;
    logic        nRst      = 1'b0;
    logic        rx_valid  = 1'b0;
    logic [15:0] rx_data   = 16'd0;
    logic        rx_is_cmd = 1'b0;
    logic        rx_error  = 1'b0;
    logic        push_request;
    logic [15:0] push_data;
    logic        push_done = 1'b0;
    logic        rb_open;
    logic        rb_commit;
    logic        rb_rollback;
    logic        pkt_committed;
    logic        pkt_dropped;
    logic [7:0]  word_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int push_cnt = 0, open_cnt = 0, commit_cnt = 0, rollback_cnt = 0;
    int drop_cnt = 0, committed_cnt = 0, mem_used = 0, pend = 0, violations = 0;
    int last_ack_cyc = 0, commit_cyc = 0, open_cyc = 0, first_req_cyc = 0;
    bit req_since_open = 1'b0;
    logic [15:0] push_log[$];

    bit ack_enable = 1'b1;
    int ack_wait   = 0;

    logic        prev_req  = 1'b0;
    logic        prev_done = 1'b0;
    logic [15:0] prev_data = 16'd0;

    mil_rx_packet_pusher #(
        .GAP_TIMEOUT(GAP),
        .MAX_WORDS  (MAXW)
    ) dut (
        .clk          (clk),
        .nRst         (nRst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_is_cmd    (rx_is_cmd),
        .rx_error     (rx_error),
        .push_request (push_request),
        .push_data    (push_data),
        .push_done    (push_done),
        .rb_open      (rb_open),
        .rb_commit    (rb_commit),
        .rb_rollback  (rb_rollback),
        .pkt_committed(pkt_committed),
        .pkt_dropped  (pkt_dropped),
        .word_count   (word_count)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Ring-side responder: acknowledges a pending push two cycles after it appears.
    always @(posedge clk) begin
        #1;
        if (!nRst) begin
            push_done = 1'b0;
            ack_wait  = 0;
        end else if (push_done) begin
            push_done = 1'b0;
        end else if (ack_enable && push_request) begin
            if (ack_wait >= 1) begin
                push_done = 1'b1;
                ack_wait  = 0;
            end else begin
                ack_wait++;
            end
        end else begin
            ack_wait = 0;
        end
    end

    // Ring model and protocol watcher, sampled mid-cycle.
    always @(negedge clk) begin
        if (!nRst) begin
            prev_req       = 1'b0;
            prev_done      = 1'b0;
            req_since_open = 1'b0;
        end else begin
            if ((int'(rb_open) + int'(rb_commit) + int'(rb_rollback)) > 1) violations++;
            if (pkt_committed !== rb_commit) violations++;
            if (prev_req && !prev_done && !push_request) violations++;
            if (prev_req && !prev_done && push_data !== prev_data) violations++;
            if (rb_open) begin
                open_cnt++;
                open_cyc       = cyc;
                pend           = 0;
                req_since_open = 1'b0;
            end
            if (push_request && !req_since_open) begin
                req_since_open = 1'b1;
                first_req_cyc  = cyc;
            end
            if (push_request && push_done) begin
                push_cnt++;
                pend++;
                push_log.push_back(push_data);
                last_ack_cyc = cyc;
            end
            if (rb_commit) begin
                commit_cnt++;
                commit_cyc = cyc;
                mem_used  += pend;
                pend       = 0;
            end
            if (pkt_committed) committed_cnt++;
            if (rb_rollback) begin
                rollback_cnt++;
                pend = 0;
            end
            if (pkt_dropped) drop_cnt++;
            prev_req  = push_request;
            prev_done = push_done;
            prev_data = push_data;
        end
    end

    task automatic send_word(input logic [15:0] d, input logic cmd, input logic err);
        @(posedge clk); #1;
        rx_valid  = 1'b1;
        rx_data   = d;
        rx_is_cmd = cmd;
        rx_error  = err;
        @(posedge clk); #1;
        rx_valid  = 1'b0;
        rx_is_cmd = 1'b0;
        rx_error  = 1'b0;
    endtask

    task automatic send_error();
        @(posedge clk); #1;
        rx_error = 1'b1;
        @(posedge clk); #1;
        rx_error = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // which: 0 = pushes, 1 = commits, 2 = rollbacks
    task automatic wait_count(input int which, input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if ((which == 0 && push_cnt >= target) ||
                (which == 1 && commit_cnt >= target) ||
                (which == 2 && rollback_cnt >= target)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({push_request, push_data, rb_open, rb_commit, rb_rollback, pkt_committed, pkt_dropped, word_count} !== 30'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got push_request=%b push_data=%h word_count=%0d expected all zero",
                     push_request, push_data, word_count);
        end
        idle(3);
        nRst = 1'b1;
        idle(3);
        checks++;
        if (word_count !== 8'd0 || push_request !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release: got word_count=%0d push_request=%b expected 0 and 0", word_count, push_request);
        end
    endtask

    task automatic test_single_packet();
        int p0, c0, r0, m0, o0, k0;
        bit ok;
        p0 = push_cnt; c0 = commit_cnt; r0 = rollback_cnt; m0 = mem_used; o0 = open_cnt; k0 = committed_cnt;
        send_word(16'h0821, 1'b1, 1'b0);
        wait_count(0, p0 + 1, 50, ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL t1_cmd_push: got timeout expected push of command"); end
        checks++;
        if (open_cnt - o0 != 1 || first_req_cyc - open_cyc != 1) begin
            failures++;
            $display("[TB] FAIL t1_open: got opens=%0d open_to_req=%0d expected 1 and 1", open_cnt - o0, first_req_cyc - open_cyc);
        end
        idle(50);
        send_word(16'hABCD, 1'b0, 1'b0);
        wait_count(0, p0 + 2, 50, ok);
        idle(1);
        checks++;
        if (!ok || word_count !== 8'd2) begin
            failures++;
            $display("[TB] FAIL t1_word_count: got ok=%0d word_count=%0d expected 1 and 2", ok, word_count);
        end
        idle(50);
        send_word(16'h1234, 1'b0, 1'b0);
        wait_count(0, p0 + 3, 50, ok);
        wait_count(1, c0 + 1, 400, ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL t1_commit: got timeout expected rb_commit"); end
        checks++;
        if (commit_cyc - last_ack_cyc != int'(GAP) + 1) begin
            failures++;
            $display("[TB] FAIL t1_gap: got %0d cycles expected %0d", commit_cyc - last_ack_cyc, int'(GAP) + 1);
        end
        checks++;
        if (push_cnt - p0 != 3 || push_log[p0] !== 16'h0821 || push_log[p0 + 1] !== 16'hABCD || push_log[p0 + 2] !== 16'h1234) begin
            failures++;
            $display("[TB] FAIL t1_push_order: got %0d pushes first=%h expected 3 pushes 0821 ABCD 1234", push_cnt - p0, push_log[p0]);
        end
        idle(2);
        checks++;
        if (mem_used - m0 != 3 || committed_cnt - k0 != 1 || rollback_cnt != r0 || word_count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL t1_result: got mem=%0d committed=%0d rollbacks=%0d word_count=%0d expected 3 1 0 0",
                     mem_used - m0, committed_cnt - k0, rollback_cnt - r0, word_count);
        end
    endtask

    task automatic test_error_rollback();
        int p0, c0, r0, m0, d0;
        bit ok;
        p0 = push_cnt; c0 = commit_cnt; r0 = rollback_cnt; m0 = mem_used; d0 = drop_cnt;
        send_word(16'h0821, 1'b1, 1'b0);
        wait_count(0, p0 + 1, 50, ok);
        send_word(16'h1111, 1'b0, 1'b0);
        wait_count(0, p0 + 2, 50, ok);
        send_error();
        wait_count(2, r0 + 1, 20, ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL t2_rollback: got timeout expected rb_rollback"); end
        idle(5);
        checks++;
        if (rollback_cnt - r0 != 1 || commit_cnt != c0 || mem_used != m0 || drop_cnt - d0 != 1) begin
            failures++;
            $display("[TB] FAIL t2_result: got rollbacks=%0d commits=%0d mem=%0d drops=%0d expected 1 0 0 1",
                     rollback_cnt - r0, commit_cnt - c0, mem_used - m0, drop_cnt - d0);
        end
        idle(250);
        send_word(16'h0822, 1'b1, 1'b0);
        wait_count(0, p0 + 3, 50, ok);
        send_word(16'h2222, 1'b0, 1'b0);
        wait_count(1, c0 + 1, 400, ok);
        checks++;
        if (!ok || mem_used - m0 != 2) begin
            failures++;
            $display("[TB] FAIL t2_recover: got ok=%0d mem=%0d expected 1 and 2", ok, mem_used - m0);
        end
    endtask

    task automatic test_data_in_idle();
        int p0, o0, d0, c0;
        bit ok;
        p0 = push_cnt; o0 = open_cnt; d0 = drop_cnt; c0 = commit_cnt;
        send_word(16'h5555, 1'b0, 1'b0);
        idle(3);
        checks++;
        if (drop_cnt - d0 != 1 || open_cnt != o0 || push_cnt != p0) begin
            failures++;
            $display("[TB] FAIL t3_drop: got drops=%0d opens=%0d pushes=%0d expected 1 0 0", drop_cnt - d0, open_cnt - o0, push_cnt - p0);
        end
        idle(100);
        send_word(16'h0821, 1'b1, 1'b0);
        idle(150);
        checks++;
        if (open_cnt != o0 || push_cnt != p0) begin
            failures++;
            $display("[TB] FAIL t3_discard: got opens=%0d pushes=%0d expected 0 0", open_cnt - o0, push_cnt - p0);
        end
        idle(100);
        send_word(16'h0831, 1'b1, 1'b0);
        wait_count(1, c0 + 1, 400, ok);
        checks++;
        if (!ok || open_cnt - o0 != 1) begin
            failures++;
            $display("[TB] FAIL t3_reopen: got ok=%0d opens=%0d expected 1 and 1", ok, open_cnt - o0);
        end
    endtask

    task automatic test_back_to_back();
        int p0, c0, r0, m0;
        bit ok;
        bit all_ok;
        p0 = push_cnt; c0 = commit_cnt; r0 = rollback_cnt; m0 = mem_used;
        all_ok = 1'b1;
        send_word(16'h0821, 1'b1, 1'b0);
        wait_count(0, p0 + 1, 50, ok);
        all_ok &= ok;
        for (int i = 1; i < int'(MAXW); i++) begin
            send_word(16'h1000 + 16'(i), 1'b0, 1'b0);
            wait_count(0, p0 + 1 + i, 50, ok);
            all_ok &= ok;
        end
        @(posedge clk); #1;
        checks++;
        if (!all_ok || word_count !== MAXW || push_cnt - p0 != int'(MAXW) || rollback_cnt != r0) begin
            failures++;
            $display("[TB] FAIL t4_full: got ok=%0d word_count=%0d pushes=%0d rollbacks=%0d expected 1 33 33 0",
                     all_ok, word_count, push_cnt - p0, rollback_cnt - r0);
        end
        send_word(16'h2034, 1'b0, 1'b0);
        wait_count(2, r0 + 1, 20, ok);
        idle(5);
        checks++;
        if (!ok || push_cnt - p0 != int'(MAXW) || mem_used != m0 || commit_cnt != c0) begin
            failures++;
            $display("[TB] FAIL t4_overflow: got ok=%0d pushes=%0d mem=%0d commits=%0d expected 1 33 0 0",
                     ok, push_cnt - p0, mem_used - m0, commit_cnt - c0);
        end
        idle(250);
    endtask

    task automatic test_overrun();
        int p0, c0, r0;
        bit ok;
        p0 = push_cnt; c0 = commit_cnt; r0 = rollback_cnt;
        ack_enable = 1'b0;
        send_word(16'h0821, 1'b1, 1'b0);
        idle(300);
        checks++;
        if (push_request !== 1'b1 || push_data !== 16'h0821 || push_cnt != p0) begin
            failures++;
            $display("[TB] FAIL t5_stall: got push_request=%b push_data=%h pushes=%0d expected 1 0821 0",
                     push_request, push_data, push_cnt - p0);
        end
        send_word(16'h3333, 1'b0, 1'b0);
        idle(10);
        checks++;
        if (rollback_cnt != r0 || push_request !== 1'b1 || push_data !== 16'h0821) begin
            failures++;
            $display("[TB] FAIL t5_hold: got rollbacks=%0d push_request=%b push_data=%h expected 0 1 0821",
                     rollback_cnt - r0, push_request, push_data);
        end
        ack_enable = 1'b1;
        wait_count(2, r0 + 1, 30, ok);
        checks++;
        if (!ok || push_cnt - p0 != 1 || push_log[p0] !== 16'h0821 || commit_cnt != c0) begin
            failures++;
            $display("[TB] FAIL t5_rollback: got ok=%0d pushes=%0d commits=%0d expected 1 1 0", ok, push_cnt - p0, commit_cnt - c0);
        end
        idle(250);
    endtask

    task automatic test_reset_mid_packet();
        int c0, r0;
        bit ok;
        c0 = commit_cnt; r0 = rollback_cnt;
        ack_enable = 1'b0;
        send_word(16'h0777, 1'b1, 1'b0);
        idle(3);
        checks++;
        if (push_request !== 1'b1) begin
            failures++;
            $display("[TB] FAIL t6_in_push: got push_request=%b expected 1", push_request);
        end
        #3;
        nRst = 1'b0;
        #1;
        checks++;
        if ({push_request, push_data, rb_open, rb_commit, rb_rollback, pkt_committed, pkt_dropped, word_count} !== 30'd0) begin
            failures++;
            $display("[TB] FAIL t6_async_reset: got push_request=%b push_data=%h word_count=%0d expected all zero",
                     push_request, push_data, word_count);
        end
        idle(3);
        nRst = 1'b1;
        ack_enable = 1'b1;
        idle(2);
        checks++;
        if (word_count !== 8'd0 || push_request !== 1'b0 || commit_cnt != c0 || rollback_cnt != r0) begin
            failures++;
            $display("[TB] FAIL t6_after_reset: got word_count=%0d push_request=%b commits=%0d rollbacks=%0d expected 0 0 0 0",
                     word_count, push_request, commit_cnt - c0, rollback_cnt - r0);
        end
        send_word(16'h0888, 1'b1, 1'b0);
        wait_count(1, c0 + 1, 400, ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL t6_recover: got timeout expected rb_commit"); end
    endtask

    task automatic test_protocol();
        checks++;
        if (violations != 0) begin
            failures++;
            $display("[TB] FAIL protocol: got %0d violations expected 0", violations);
        end
    endtask

    // Scenario sequence followed by the summary.
    initial begin
        test_reset();
        test_single_packet();
        test_error_rollback();
        test_data_in_idle();
        test_back_to_back();
        test_overrun();
        test_reset_mid_packet();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    // Hard stop in case a scenario wedges.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

endmodule
